rgmii_tx_multi: RTL and testbench

Runtime speed-selectable RGMII transmit PHY interface that replaces the fixed-rate RGMII transmitter between the MAC byte stream and the PHY pins. It supports 1000 Mb/s DDR, 100 Mb/s and 10 Mb/s nibble modes, TX_ER signalling, and a valid/ready byte handshake so the MAC can be throttled at 10/100. In every mode it forwards TXC from the system clock, using a clock divider for 10/100 and an ODDR-generated clock for 1000. The PHY is configured for RGMII-ID, so it supplies the TXC delay internally.

---
 rtl/rgmii_pkg.sv | 24 ++
 rtl/oddr.sv | 28 ++
 rtl/rgmii_sdr_div.sv | 34 +++
 rtl/rgmii_tx_multi.sv | 149 ++++++++++++++
 tb/tb_rgmii_tx_multi.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgmii_pkg.sv
// Shared types and constants for the runtime speed-selectable RGMII transmitter.
package rgmii_pkg;

    typedef enum logic [1:0] {
        SPEED_10   = 2'b00,
        SPEED_100  = 2'b01,
        SPEED_1000 = 2'b10,
        SPEED_RSVD = 2'b11
    } speed_t;

    typedef enum logic [1:0] {
        NIB_IDLE = 2'b00,
        NIB_LO   = 2'b01,
        NIB_HI   = 2'b10
    } nib_state_t;

    localparam int DIV_100_DEFAULT = 5;
    localparam int DIV_10_DEFAULT  = 50;

    function automatic logic is_sdr(input speed_t s);
        return (s == SPEED_10) || (s == SPEED_100);
    endfunction

endpackage

// File: rtl/oddr.sv
// Generic DDR output register: d1 is driven while clk is high, d2 while clk is low.
module oddr #(
    parameter int INPUT_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_WIDTH-1:0] d1,
    input  logic [INPUT_WIDTH-1:0] d2,
    output logic [INPUT_WIDTH-1:0] q
);

    logic [INPUT_WIDTH-1:0] d1_q;
    logic [INPUT_WIDTH-1:0] d2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d1_q <= '0;
            d2_q <= '0;
        end else begin
            d1_q <= d1;
            d2_q <= d2;
        end
    end

    // Both halves are captured on the rising edge so the pair launches in one cycle.
    assign q = clk ? d1_q : d2_q;

endmodule

// File: rtl/rgmii_sdr_div.sv
// TXC divider for 10/100 modes: counts 0..div-1 and forms the single-rate TXC.
module rgmii_sdr_div #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [CNT_W-1:0] div,
    output logic             cnt_wrap,
    output logic             txc_sdr
);

    logic [CNT_W-1:0] cnt;
    logic             run;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            run <= 1'b0;
        end else begin
            run <= 1'b1;
            if (restart || cnt_wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // >= keeps the counter from running away if div shrinks without a restart.
    assign cnt_wrap = (cnt >= div - 1'b1);
    assign txc_sdr  = run && (cnt < (div >> 1));

endmodule

// File: rtl/rgmii_tx_multi.sv
// RGMII transmitter with runtime 10/100/1000 selection; DDR path for 1000, nibble path for 10/100.
module rgmii_tx_multi
    import rgmii_pkg::*;
#(
    parameter int     DIV_100       = DIV_100_DEFAULT,
    parameter int     DIV_10        = DIV_10_DEFAULT,
    parameter speed_t DEFAULT_SPEED = SPEED_1000
) (
    input  logic       clk,
    input  logic       rst,
    input  speed_t     speed,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_er,
    output logic       tx_ready,
    output logic       tx_busy,
    output speed_t     speed_active,
    output logic       phy_txc,
    output logic       phy_txctl,
    output logic [3:0] phy_txd
);

    localparam int DIV_MAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
    localparam int CNT_W   = $clog2(DIV_MAX + 1);

    logic             sdr_mode;
    logic [CNT_W-1:0] div;
    logic             cnt_wrap;
    logic             txc_sdr;
    logic             restart;
    logic             run;
    logic             accept;

    assign sdr_mode = is_sdr(speed_active);
    assign div      = (speed_active == SPEED_10) ? CNT_W'(DIV_10) : CNT_W'(DIV_100);

    // Speed only changes between frames; a no-op or reserved request must not disturb the divider.
    assign restart = !tx_busy && !tx_valid && (speed != SPEED_RSVD) && (speed != speed_active);

    always_ff @(posedge clk) begin
        if (rst) begin
            speed_active <= DEFAULT_SPEED;
            run          <= 1'b0;
        end else begin
            run <= 1'b1;
            if (restart) begin
                speed_active <= speed;
            end
        end
    end

    rgmii_sdr_div #(.CNT_W(CNT_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .div      (div),
        .cnt_wrap (cnt_wrap),
        .txc_sdr  (txc_sdr)
    );

    nib_state_t state;

    assign tx_ready = run && (sdr_mode ? (cnt_wrap && (state != NIB_LO)) : 1'b1);
    assign accept   = tx_valid && tx_ready;

    // 1000 path
    logic       ddr_acc;
    logic       ddr_en;
    logic [3:0] ddr_d1;
    logic [3:0] ddr_d2;
    logic       ctl_d1;
    logic       ctl_d2;
    logic [3:0] ddr_txd;
    logic       ddr_ctl;
    logic       ddr_txc;

    assign ddr_acc = accept && !sdr_mode;
    assign ddr_d1  = ddr_acc ? tx_data[3:0] : 4'h0;
    assign ddr_d2  = ddr_acc ? tx_data[7:4] : 4'h0;
    assign ctl_d1  = ddr_acc;
    assign ctl_d2  = ddr_acc && !tx_er;

    always_ff @(posedge clk) begin
        if (rst) begin
            ddr_en <= 1'b0;
        end else begin
            ddr_en <= ddr_acc;
        end
    end

    oddr #(.INPUT_WIDTH(4)) u_oddr_txd (
        .clk (clk), .rst (rst), .d1 (ddr_d1), .d2 (ddr_d2), .q (ddr_txd)
    );

    oddr #(.INPUT_WIDTH(1)) u_oddr_ctl (
        .clk (clk), .rst (rst), .d1 (ctl_d1), .d2 (ctl_d2), .q (ddr_ctl)
    );

    oddr #(.INPUT_WIDTH(1)) u_oddr_txc (
        .clk (clk), .rst (rst), .d1 (1'b1), .d2 (1'b0), .q (ddr_txc)
    );

    // 10/100 path: everything moves on the wrap so pins change only at cnt=0.
    logic [3:0] hold_hi;
    logic       hold_er;
    logic       sdr_en;
    logic [3:0] sdr_txd;
    logic       sdr_ctl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= NIB_IDLE;
            hold_hi <= 4'h0;
            hold_er <= 1'b0;
            sdr_en  <= 1'b0;
            sdr_txd <= 4'h0;
        end else if (sdr_mode && cnt_wrap) begin
            if (accept) begin
                state   <= NIB_LO;
                hold_hi <= tx_data[7:4];
                hold_er <= tx_er;
                sdr_en  <= 1'b1;
                sdr_txd <= tx_data[3:0];
            end else begin
                case (state)
                    NIB_LO: begin
                        state   <= NIB_HI;
                        sdr_txd <= hold_hi;
                    end
                    NIB_HI: begin
                        state   <= NIB_IDLE;
                        sdr_txd <= 4'h0;
                        sdr_en  <= 1'b0;
                        hold_er <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sdr_ctl = txc_sdr ? sdr_en : (sdr_en ^ hold_er);

    assign tx_busy   = sdr_mode ? (state != NIB_IDLE) : ddr_en;
    assign phy_txd   = sdr_mode ? sdr_txd : ddr_txd;
    assign phy_txctl = sdr_mode ? sdr_ctl : ddr_ctl;
    assign phy_txc   = sdr_mode ? txc_sdr : ddr_txc;

endmodule

// File: tb/tb_rgmii_tx_multi.sv
// Bench for rgmii_tx_multi: 1000-mode vector table, directed 10/100 sequences and a timeline reference model.
module tb_rgmii_tx_multi;
    import rgmii_pkg::*;

    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst;
    speed_t     speed;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_er;
    logic       tx_ready;
    logic       tx_busy;
    speed_t     speed_active;
    logic       phy_txc;
    logic       phy_txctl;
    logic [3:0] phy_txd;

    rgmii_tx_multi #(.DIV_100(5), .DIV_10(50), .DEFAULT_SPEED(SPEED_1000)) dut (
        .clk          (clk),
        .rst          (rst),
        .speed        (speed),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_er        (tx_er),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .speed_active (speed_active),
        .phy_txc      (phy_txc),
        .phy_txctl    (phy_txctl),
        .phy_txd      (phy_txd)
    );

    always #4 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [3:0] r_txd, f_txd;
    logic       r_ctl, f_ctl, r_txc, f_txc, r_rdy, r_busy;
    speed_t     r_spd;

    // Expected pin timeline, indexed by cycle; unfilled entries mean idle.
    bit [3:0] e_txd_r [MAXC];
    bit [3:0] e_txd_f [MAXC];
    bit       e_ctl_r [MAXC];
    bit       e_ctl_f [MAXC];
    bit       e_busy  [MAXC];
    bit       e_txc   [MAXC];
    bit       e_txcv  [MAXC];
    bit       e_rdy   [MAXC];
    bit       e_rdyv  [MAXC];

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       er;
        logic [3:0] txd_r;
        logic [3:0] txd_f;
        logic       ctl_r;
        logic       ctl_f;
        logic       busy;
    } vec_t;

    vec_t vec [8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: rising-half sample after posedge, falling-half sample after negedge.
    // Inputs written after step() apply to the current cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        r_txd  = phy_txd;
        r_ctl  = phy_txctl;
        r_txc  = phy_txc;
        r_rdy  = tx_ready;
        r_busy = tx_busy;
        r_spd  = speed_active;
        @(negedge clk);
        #1;
        f_txd = phy_txd;
        f_ctl = phy_txctl;
        f_txc = phy_txc;
    endtask

    task automatic wait_rdy(input int lim, output int t);
        t = -1;
        for (int i = 0; i < lim; i++) begin
            if (r_rdy) begin
                t = cyc;
                break;
            end
            step();
        end
        if (t < 0) chk("rdy_timeout", 0, 1);
    endtask

    task automatic set_speed(input speed_t s, output int t_sw);
        speed    = s;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_er    = 1'b0;
        for (int i = 0; i < 400 && r_spd != s; i++) step();
        chk("speed_switch", r_spd, s);
        t_sw = cyc;
    endtask

    // Byte accepted in cycle t: 1000 shows it at t+1; 10/100 shows lo then hi nibble for d cycles each.
    task automatic fill(input int t, input int d, input logic [7:0] b, input logic er);
        int  k;
        bit  hp;
        if (t + 2 * d + 2 >= MAXC) begin
            chk("model_range", t, 0);
            return;
        end
        if (d == 0) begin
            e_txd_r[t+1] = b[3:0];
            e_txd_f[t+1] = b[7:4];
            e_ctl_r[t+1] = 1'b1;
            e_ctl_f[t+1] = !er;
            e_busy[t+1]  = 1'b1;
        end else begin
            for (int j = 1; j <= 2 * d; j++) begin
                k  = t + j;
                hp = ((j - 1) % d) < (d / 2);
                e_txd_r[k] = (j <= d) ? b[3:0] : b[7:4];
                e_txcv[k]  = 1'b1;
                e_txc[k]   = hp;
                e_ctl_r[k] = hp ? 1'b1 : !er;
                e_busy[k]  = 1'b1;
                e_rdyv[k]  = 1'b1;
                e_rdy[k]   = (j == 2 * d);
            end
        end
    endtask

    task automatic check_model(input int d);
        chk("m_txd_r", r_txd, e_txd_r[cyc]);
        chk("m_ctl_r", r_ctl, e_ctl_r[cyc]);
        chk("m_busy", r_busy, e_busy[cyc]);
        if (d == 0) begin
            chk("m_txd_f", f_txd, e_txd_f[cyc]);
            chk("m_ctl_f", f_ctl, e_ctl_f[cyc]);
            chk("m_txc_r", r_txc, 1);
            chk("m_txc_f", f_txc, 0);
            chk("m_rdy", r_rdy, 1);
        end else begin
            chk("m_txd_stable", f_txd, e_txd_r[cyc]);
            if (e_txcv[cyc]) chk("m_txc", r_txc, e_txc[cyc]);
            if (e_rdyv[cyc]) chk("m_rdy", r_rdy, e_rdy[cyc]);
        end
    endtask

    // Random frame at divider d (0 = 1000 mode), checked every cycle against the timeline.
    task automatic run_frame(input int d, input int nbytes, input bit use_er);
        logic [8:0] q[$];
        int t_last = -1;
        int t_end  = -1;
        int budget;
        for (int i = 0; i < nbytes; i++)
            q.push_back({use_er && ($urandom_range(0, 3) == 0), 8'($urandom)});
        budget = nbytes * (2 * d + 1) + 2 * d + 40;
        while (1) begin
            if (q.size() > 0) begin
                tx_valid = 1'b1;
                tx_data  = q[0][7:0];
                tx_er    = q[0][8];
            end else begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
                tx_er    = 1'b0;
            end
            if (tx_valid && r_rdy) begin
                fill(cyc, d, q[0][7:0], q[0][8]);
                void'(q.pop_front());
                t_last = cyc;
            end
            if (q.size() == 0 && t_end < 0)
                t_end = t_last + ((d == 0) ? 1 : 2 * d) + 2;
            step();
            check_model(d);
            if (t_end >= 0 && cyc > t_end) break;
            budget--;
            if (budget == 0) begin
                chk("frame_timeout", 0, 1);
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, tsw;
        bit hp;

        vec[0] = '{1'b1, 8'h55, 1'b0, 4'h5, 4'h5, 1'b1, 1'b1, 1'b1};
        vec[1] = '{1'b1, 8'hD5, 1'b0, 4'h5, 4'hD, 1'b1, 1'b1, 1'b1};
        vec[2] = '{1'b1, 8'hA3, 1'b0, 4'h3, 4'hA, 1'b1, 1'b1, 1'b1};
        vec[3] = '{1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        vec[4] = '{1'b1, 8'h7E, 1'b1, 4'hE, 4'h7, 1'b1, 1'b0, 1'b1};
        vec[5] = '{1'b0, 8'hFF, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        vec[6] = '{1'b1, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1};
        vec[7] = '{1'b0, 8'h12, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; speed = SPEED_1000; tx_valid = 1'b0; tx_data = 8'h00; tx_er = 1'b0;
        step();
        step();
        chk("rst_txd", r_txd, 0);
        chk("rst_txd_f", f_txd, 0);
        chk("rst_ctl", r_ctl, 0);
        chk("rst_ctl_f", f_ctl, 0);
        chk("rst_txc", r_txc, 0);
        chk("rst_txc_f", f_txc, 0);
        chk("rst_rdy", r_rdy, 0);
        chk("rst_busy", r_busy, 0);
        chk("rst_spd", r_spd, SPEED_1000);
        rst = 1'b0;
        step();
        chk("post_rst_rdy", r_rdy, 1);

        // 1000 mode vector table
        for (int i = 0; i < 8; i++) begin
            tx_valid = vec[i].valid;
            tx_data  = vec[i].data;
            tx_er    = vec[i].er;
            chk("v_rdy", r_rdy, 1);
            step();
            chk("v_txd_r", r_txd, vec[i].txd_r);
            chk("v_txd_f", f_txd, vec[i].txd_f);
            chk("v_ctl_r", r_ctl, vec[i].ctl_r);
            chk("v_ctl_f", f_ctl, vec[i].ctl_f);
            chk("v_busy", r_busy, vec[i].busy);
            chk("v_txc_r", r_txc, 1);
            chk("v_txc_f", f_txc, 0);
        end

        // 100 mode, single byte 0x3C
        set_speed(SPEED_100, tsw);
        tx_valid = 1'b1; tx_data = 8'h3C; tx_er = 1'b0;
        wait_rdy(20, t);
        chk("rdy100_first", t, tsw + 4);
        step();
        tx_valid = 1'b0; tx_data = 8'h00;
        for (int j = 1; j <= 10; j++) begin
            hp = ((j - 1) % 5) < 2;
            chk("b100_txd", r_txd, (j <= 5) ? 4'hC : 4'h3);
            chk("b100_txc", r_txc, hp);
            chk("b100_ctl", r_ctl, 1);
            chk("b100_busy", r_busy, 1);
            chk("b100_rdy", r_rdy, (j == 10) ? 1 : 0);
            step();
        end
        chk("b100_end_txd", r_txd, 0);
        chk("b100_end_ctl", r_ctl, 0);
        chk("b100_end_busy", r_busy, 0);

        // 10 mode, tx_er on 0x00, with a 1000 request pending for the whole frame
        set_speed(SPEED_10, tsw);
        tx_valid = 1'b1; tx_data = 8'h00; tx_er = 1'b1;
        wait_rdy(60, t);
        chk("rdy10_first", t, tsw + 49);
        step();
        tx_valid = 1'b0; tx_er = 1'b0; speed = SPEED_1000;
        for (int j = 1; j <= 100; j++) begin
            hp = ((j - 1) % 50) < 25;
            chk("b10_txc", r_txc, hp);
            chk("b10_ctl", r_ctl, hp);
            chk("b10_txd", r_txd, 0);
            chk("b10_busy", r_busy, 1);
            chk("b10_spd_hold", r_spd, SPEED_10);
            step();
        end
        chk("sw_idle_spd", r_spd, SPEED_10);
        chk("sw_idle_busy", r_busy, 0);
        chk("sw_idle_rdy", r_rdy, 0);
        step();
        chk("sw_new_spd", r_spd, SPEED_1000);
        chk("sw_new_rdy", r_rdy, 1);

        // random traffic against the timeline model
        for (int f = 0; f < 3; f++) run_frame(0, 4 + $urandom_range(0, 8), 1'b1);
        set_speed(SPEED_100, tsw);
        for (int f = 0; f < 2; f++) run_frame(5, 3 + $urandom_range(0, 3), 1'b1);

        // reserved request while idle
        speed = SPEED_RSVD; tx_valid = 1'b0;
        repeat (12) step();
        chk("rsvd_hold", r_spd, SPEED_100);
        run_frame(5, 4, 1'b1);
        chk("rsvd_hold2", r_spd, SPEED_100);

        set_speed(SPEED_10, tsw);
        run_frame(50, 3, 1'b1);

        // reset while in the high nibble at 100
        set_speed(SPEED_100, tsw);
        tx_valid = 1'b1; tx_data = 8'hA5; tx_er = 1'b0;
        wait_rdy(20, t);
        step();
        tx_valid = 1'b0; tx_data = 8'h00;
        repeat (6) step();
        chk("pre_rst_hi_txd", r_txd, 4'hA);
        chk("pre_rst_busy", r_busy, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_txd", r_txd, 0);
        chk("mid_rst_ctl", r_ctl, 0);
        chk("mid_rst_txc", r_txc, 0);
        chk("mid_rst_txc_f", f_txc, 0);
        chk("mid_rst_rdy", r_rdy, 0);
        chk("mid_rst_busy", r_busy, 0);
        chk("mid_rst_spd", r_spd, SPEED_1000);
        rst = 1'b0;
        set_speed(SPEED_100, tsw);
        tx_valid = 1'b1; tx_data = 8'h96;
        wait_rdy(20, t);
        chk("post_rst_rdy100", t, tsw + 4);
        step();
        tx_valid = 1'b0; tx_data = 8'h00;
        chk("post_rst_lo_txd", r_txd, 4'h6);
        chk("post_rst_lo_txc", r_txc, 1);
        chk("post_rst_lo_ctl", r_ctl, 1);
        chk("post_rst_lo_busy", r_busy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
